// File: rtl/id_operand_stage_pkg.sv
// id_operand_stage_pkg: shared stall bus, stall bit indices and forwarding source indices
package id_operand_stage_pkg;
  localparam int STALL_W = 6;
  typedef logic [STALL_W-1:0] stall_bus_t;
  localparam logic STOP = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam int STALL_IF_ID = 1;
  localparam int STALL_ID_EX = 2;
  localparam int FWD_EX = 0;
  localparam int FWD_MEM = 1;
  localparam int FWD_WB = 2;
endpackage

// File: rtl/id_operand_stage_fwd_mux_port.sv
// fwd_mux_port: single-port priority forwarding mux with load-use interlock term
module fwd_mux_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_FWD = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic                      en,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         rf_rdata,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
  input  logic [NUM_FWD-1:0]        fwd_is_load,
  output logic [DATA_W-1:0]         data,
  output logic                      load_hit
);
  localparam logic [NUM_FWD-1:0] LOAD_WIN = NUM_FWD'((1 << LOAD_LAT) - 1);
  logic [NUM_FWD-1:0] hit;
  // per-source address match; r0 never matches so it always reads as zero
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_FWD; i++)
      hit[i] = fwd_we[i] && fwd_waddr[i*ADDR_W +: ADDR_W] == addr && addr != '0;
  end
  // walk oldest to youngest so the youngest matching source overwrites last
  always_comb begin
    data = addr == '0 ? '0 : rf_rdata;
    for (int i = NUM_FWD - 1; i >= 0; i--)
      if (hit[i]) data = fwd_wdata[i*DATA_W +: DATA_W];
  end
  // loads still inside the latency window cannot be forwarded yet
  always_comb load_hit = en && |(hit & fwd_is_load & LOAD_WIN);
endmodule

// File: rtl/id_operand_stage.sv
// id_operand_stage: IF/ID register, stall hold buffer, operand forwarding and load-use interlock
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_FWD = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  stall_bus_t                stall,
  input  logic                      if_ce,
  input  logic [31:0]               if_pc,
  input  logic [31:0]               inst_sram_rdata,
  input  logic [NUM_RD-1:0]         rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
  input  logic [NUM_RD*DATA_W-1:0]  rf_rdata,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
  input  logic [NUM_FWD-1:0]        fwd_is_load,
  output logic                      id_ce,
  output logic [31:0]               id_pc,
  output logic [31:0]               id_inst,
  output logic [NUM_RD*DATA_W-1:0]  opnd_data,
  output logic                      stallreq
);
  logic hold_vld;
  logic [31:0] hold_inst;
  logic bubble, advance, capture;
  logic [NUM_RD-1:0] load_hit;
  logic unused_stall;
  assign unused_stall = ^{stall[0], stall[STALL_W-1:3]};
  // decode the stall vector into the three register actions
  always_comb begin
    bubble = stall[STALL_IF_ID] == STOP && stall[STALL_ID_EX] == NO_STOP;
    advance = stall[STALL_IF_ID] == NO_STOP;
    capture = stall[STALL_ID_EX] == STOP && !hold_vld && !advance;
  end
  // IF/ID register plus hold buffer; the SRAM word is frozen on the first stalled edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_ce <= 1'b0;
      id_pc <= '0;
      hold_vld <= 1'b0;
      hold_inst <= '0;
    end else begin
      if (bubble) begin
        id_ce <= 1'b0;
        id_pc <= '0;
      end else if (advance) begin
        id_ce <= if_ce;
        id_pc <= if_pc;
      end
      hold_vld <= bubble || advance ? 1'b0 : capture ? 1'b1 : hold_vld;
      if (capture) hold_inst <= inst_sram_rdata;
    end
  end
  // decoder sees the held word during a stall and nothing in a bubble
  always_comb id_inst = !id_ce ? '0 : hold_vld ? hold_inst : inst_sram_rdata;
  genvar p;
  generate
    for (p = 0; p < NUM_RD; p++) begin : g_port
      fwd_mux_port #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_FWD(NUM_FWD), .LOAD_LAT(LOAD_LAT)
      ) u_port (
        .en(rd_en[p]),
        .addr(rd_addr[p*ADDR_W +: ADDR_W]),
        .rf_rdata(rf_rdata[p*DATA_W +: DATA_W]),
        .fwd_we(fwd_we),
        .fwd_waddr(fwd_waddr),
        .fwd_wdata(fwd_wdata),
        .fwd_is_load(fwd_is_load),
        .data(opnd_data[p*DATA_W +: DATA_W]),
        .load_hit(load_hit[p])
      );
    end
  endgenerate
  // a bubble carries no instruction, so it can never interlock
  always_comb stallreq = id_ce && |load_hit;
endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage: directed self-checking bench for id_operand_stage
module tb_id_operand_stage;
  import id_operand_stage_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  stall_bus_t stall = '0;
  logic if_ce = 1'b0;
  logic [31:0] if_pc = '0;
  logic [31:0] inst_sram_rdata = '0;
  logic [1:0] rd_en = '0;
  logic [9:0] rd_addr = '0;
  logic [63:0] rf_rdata = '0;
  logic [2:0] fwd_we = '0;
  logic [14:0] fwd_waddr = '0;
  logic [95:0] fwd_wdata = '0;
  logic [2:0] fwd_is_load = '0;
  logic id_ce, id_ce2, stallreq, stallreq2;
  logic [31:0] id_pc, id_pc2, id_inst, id_inst2;
  logic [63:0] opnd_data, opnd_data2;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_operand_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .if_ce(if_ce), .if_pc(if_pc),
    .inst_sram_rdata(inst_sram_rdata), .rd_en(rd_en), .rd_addr(rd_addr),
    .rf_rdata(rf_rdata), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr),
    .fwd_wdata(fwd_wdata), .fwd_is_load(fwd_is_load), .id_ce(id_ce),
    .id_pc(id_pc), .id_inst(id_inst), .opnd_data(opnd_data), .stallreq(stallreq)
  );

  id_operand_stage #(.LOAD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .stall(stall), .if_ce(if_ce), .if_pc(if_pc),
    .inst_sram_rdata(inst_sram_rdata), .rd_en(rd_en), .rd_addr(rd_addr),
    .rf_rdata(rf_rdata), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr),
    .fwd_wdata(fwd_wdata), .fwd_is_load(fwd_is_load), .id_ce(id_ce2),
    .id_pc(id_pc2), .id_inst(id_inst2), .opnd_data(opnd_data2), .stallreq(stallreq2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    inst_sram_rdata = 32'h1234_5678;
    rd_en = 2'b01;
    rd_addr = {5'd0, 5'd9};
    fwd_we = 3'b001;
    fwd_is_load = 3'b001;
    fwd_waddr = {5'd0, 5'd0, 5'd9};
    step();
    checks++; if (id_ce !== 1'b0) begin errors++; $display("FAIL reset_id_ce got %h want 0", id_ce); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_id_pc got %h want 0", id_pc); end
    checks++; if (id_inst !== 32'h0) begin errors++; $display("FAIL reset_id_inst got %h want 0", id_inst); end
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL reset_stallreq got %h want 0", stallreq); end
    fwd_we = '0;
    fwd_is_load = '0;
  endtask

  task automatic test_basic_flow();
    rst = 1'b0;
    if_ce = 1'b1;
    if_pc = 32'hBFC0_0000;
    inst_sram_rdata = 32'h2408_0001;
    step();
    checks++; if (id_ce !== 1'b1) begin errors++; $display("FAIL flow_id_ce got %h want 1", id_ce); end
    checks++; if (id_pc !== 32'hBFC0_0000) begin errors++; $display("FAIL flow_id_pc got %h want bfc00000", id_pc); end
    checks++; if (id_inst !== 32'h2408_0001) begin errors++; $display("FAIL flow_id_inst got %h want 24080001", id_inst); end
  endtask

  task automatic test_hold();
    stall = 6'b000110;
    if_pc = 32'hBFC0_0004;
    #1;
    checks++; if (id_inst !== 32'h2408_0001) begin errors++; $display("FAIL hold_c1 got %h want 24080001", id_inst); end
    step();
    inst_sram_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (id_inst !== 32'h2408_0001) begin errors++; $display("FAIL hold_c2 got %h want 24080001", id_inst); end
    step();
    checks++; if (id_inst !== 32'h2408_0001) begin errors++; $display("FAIL hold_c3 got %h want 24080001", id_inst); end
    checks++; if (id_pc !== 32'hBFC0_0000) begin errors++; $display("FAIL hold_pc got %h want bfc00000", id_pc); end
    stall = 6'b000000;
    step();
    checks++; if (id_inst !== 32'hDEAD_BEEF) begin errors++; $display("FAIL hold_release got %h want deadbeef", id_inst); end
    checks++; if (id_pc !== 32'hBFC0_0004) begin errors++; $display("FAIL hold_release_pc got %h want bfc00004", id_pc); end
  endtask

  task automatic test_forward();
    rd_en = 2'b11;
    rd_addr = {5'd4, 5'd8};
    rf_rdata = {32'h0000_0444, 32'h0000_0888};
    fwd_we = 3'b011;
    fwd_waddr = {5'd8, 5'd8, 5'd8};
    fwd_wdata = {32'h33, 32'h22, 32'h11};
    #1;
    checks++; if (opnd_data[31:0] !== 32'h11) begin errors++; $display("FAIL fwd_ex_wins got %h want 11", opnd_data[31:0]); end
    checks++; if (opnd_data[63:32] !== 32'h444) begin errors++; $display("FAIL fwd_port1_rf got %h want 444", opnd_data[63:32]); end
    fwd_we = 3'b010;
    #1;
    checks++; if (opnd_data[31:0] !== 32'h22) begin errors++; $display("FAIL fwd_mem got %h want 22", opnd_data[31:0]); end
    fwd_we = 3'b100;
    fwd_waddr = {5'd4, 5'd8, 5'd8};
    #1;
    checks++; if (opnd_data[31:0] !== 32'h888) begin errors++; $display("FAIL fwd_nomatch got %h want 888", opnd_data[31:0]); end
    checks++; if (opnd_data[63:32] !== 32'h33) begin errors++; $display("FAIL fwd_wb_port1 got %h want 33", opnd_data[63:32]); end
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL fwd_no_load got %h want 0", stallreq); end
  endtask

  task automatic test_zero_reg();
    rd_en = 2'b01;
    rd_addr = {5'd4, 5'd0};
    rf_rdata = {32'h0, 32'h77};
    fwd_we = 3'b001;
    fwd_is_load = 3'b001;
    fwd_waddr = {5'd0, 5'd0, 5'd0};
    fwd_wdata = {32'h0, 32'h0, 32'h55};
    #1;
    checks++; if (opnd_data[31:0] !== 32'h0) begin errors++; $display("FAIL zero_opnd got %h want 0", opnd_data[31:0]); end
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL zero_stallreq got %h want 0", stallreq); end
  endtask

  task automatic test_load_use();
    rd_en = 2'b10;
    rd_addr = {5'd9, 5'd3};
    fwd_we = 3'b001;
    fwd_is_load = 3'b001;
    fwd_waddr = {5'd0, 5'd0, 5'd9};
    fwd_wdata = {32'h0, 32'h0, 32'hBAD};
    #1;
    checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL lu_ex got %h want 1", stallreq); end
    checks++; if (stallreq2 !== 1'b1) begin errors++; $display("FAIL lu2_ex got %h want 1", stallreq2); end
    rd_en = 2'b01;
    #1;
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL lu_rd_en_off got %h want 0", stallreq); end
    rd_en = 2'b10;
    fwd_we = 3'b010;
    fwd_is_load = 3'b010;
    fwd_waddr = {5'd0, 5'd9, 5'd0};
    fwd_wdata = {32'h0, 32'hABCD, 32'h0};
    #1;
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL lu_mem got %h want 0", stallreq); end
    checks++; if (opnd_data[63:32] !== 32'hABCD) begin errors++; $display("FAIL lu_mem_data got %h want abcd", opnd_data[63:32]); end
    checks++; if (stallreq2 !== 1'b1) begin errors++; $display("FAIL lu2_mem got %h want 1", stallreq2); end
    fwd_we = 3'b100;
    fwd_is_load = 3'b100;
    fwd_waddr = {5'd9, 5'd0, 5'd0};
    fwd_wdata = {32'h1357, 32'h0, 32'h0};
    #1;
    checks++; if (stallreq2 !== 1'b0) begin errors++; $display("FAIL lu2_wb got %h want 0", stallreq2); end
    checks++; if (opnd_data2[63:32] !== 32'h1357) begin errors++; $display("FAIL lu2_wb_data got %h want 1357", opnd_data2[63:32]); end
  endtask

  task automatic test_bubble();
    fwd_we = 3'b001;
    fwd_is_load = 3'b001;
    fwd_waddr = {5'd0, 5'd0, 5'd9};
    stall = 6'b000010;
    step();
    checks++; if (id_ce !== 1'b0) begin errors++; $display("FAIL bubble_id_ce got %h want 0", id_ce); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL bubble_id_pc got %h want 0", id_pc); end
    checks++; if (id_inst !== 32'h0) begin errors++; $display("FAIL bubble_id_inst got %h want 0", id_inst); end
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL bubble_stallreq got %h want 0", stallreq); end
    fwd_we = '0;
    fwd_is_load = '0;
  endtask

  task automatic test_reset_mid_stall();
    stall = 6'b000000;
    step();
    stall = 6'b000110;
    inst_sram_rdata = 32'h1111_0000;
    step();
    inst_sram_rdata = 32'h2222_0000;
    #1;
    checks++; if (id_inst !== 32'h1111_0000) begin errors++; $display("FAIL rms_held got %h want 11110000", id_inst); end
    rst = 1'b1;
    #1;
    checks++; if (id_inst !== 32'h0) begin errors++; $display("FAIL rms_inst got %h want 0", id_inst); end
    checks++; if (id_ce !== 1'b0) begin errors++; $display("FAIL rms_ce got %h want 0", id_ce); end
    rst = 1'b0;
    stall = 6'b000000;
    inst_sram_rdata = 32'h3333_0000;
    step();
    checks++; if (id_inst !== 32'h3333_0000) begin errors++; $display("FAIL rms_fetch got %h want 33330000", id_inst); end
    stall = 6'b000110;
    step();
    inst_sram_rdata = 32'h4444_0000;
    #1;
    checks++; if (id_inst !== 32'h3333_0000) begin errors++; $display("FAIL rms_recapture got %h want 33330000", id_inst); end
    stall = 6'b000000;
  endtask

  initial begin
    test_reset();
    test_basic_flow();
    test_hold();
    test_forward();
    test_zero_reg();
    test_load_use();
    test_bubble();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
